// File: rtl/hyperbus_trx_timer.sv
// HyperBus transaction timer: chip-select decode, CS-low window sequencing with burst
// splitting, CS-high and read/write recovery timing, and completion/error pulses.
module hyperbus_trx_timer #(
  parameter int NumChips   = 2,
  parameter int AddrWidth  = 32,
  parameter int BurstWidth = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [BurstWidth-1:0]                t_burst_max_i,
  input  logic [3:0]                           t_csh_cycles_i,
  input  logic [3:0]                           t_rwr_i,
  input  logic [NumChips-1:0][AddrWidth-1:0]   chip_start_i,
  input  logic [NumChips-1:0][AddrWidth-1:0]   chip_end_i,
  input  logic                                 trx_valid_i,
  output logic                                 trx_ready_o,
  input  logic [AddrWidth-1:0]                 trx_addr_i,
  input  logic [BurstWidth-1:0]                trx_len_i,
  input  logic                                 beat_i,
  output logic [NumChips-1:0]                  cs_no,
  output logic [AddrWidth-1:0]                 cur_addr_o,
  output logic                                 restart_o,
  output logic                                 trx_done_o,
  output logic                                 trx_error_o,
  output logic                                 trans_active_o
);

  localparam int CntW = (BurstWidth > 4) ? BurstWidth : 4;
  localparam logic [BurstWidth-1:0] LenOne   = 1;
  localparam logic [CntW-1:0]       CntOne   = 1;
  localparam logic [AddrWidth-1:0]  AddrStep = 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, CSH, RWR} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  split_q, split_d;
  logic                  done_d, error_d, restart_d;
  logic [BurstWidth-1:0] remain_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [NumChips-1:0]   sel_q;
  logic [BurstWidth-1:0] limit_q;
  logic [3:0]            csh_q;
  logic [3:0]            rwr_q;

  logic [NumChips-1:0]   hit_sel;
  logic                  hit;
  logic                  accept;
  logic [CntW-1:0]       csh_load;
  logic [CntW-1:0]       rwr_load;

  // Lowest-index chip wins when ranges overlap.
  always_comb begin
    hit_sel = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < NumChips; i++) begin
      if (!hit && (chip_start_i[i] <= trx_addr_i) && (trx_addr_i < chip_end_i[i])) begin
        hit_sel[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  assign accept   = trx_valid_i && (state_q == IDLE);
  // Timers count down to zero; CSH always lasts at least one cycle.
  assign csh_load = (csh_q == 4'd0) ? '0 : CntW'(csh_q - 4'd1);
  assign rwr_load = CntW'(rwr_q - 4'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    split_d   = split_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    restart_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!hit) begin
            error_d = 1'b1;
          end else if (trx_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ACTIVE;
            cnt_d   = '0;
            split_d = 1'b0;
          end
        end
      end
      ACTIVE: begin
        cnt_d = cnt_q + CntOne;
        if (beat_i && (remain_q == LenOne)) begin
          state_d = CSH;
          cnt_d   = csh_load;
          split_d = 1'b0;
        end else if ((limit_q != '0) && (cnt_q == CntW'(limit_q - LenOne))) begin
          state_d = CSH;
          cnt_d   = csh_load;
          split_d = 1'b1;
        end
      end
      CSH, RWR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if ((state_q == CSH) && (rwr_q != 4'd0)) begin
          state_d = RWR;
          cnt_d   = rwr_load;
        end else if (split_q) begin
          state_d   = ACTIVE;
          cnt_d     = '0;
          restart_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      split_q     <= 1'b0;
      trx_done_o  <= 1'b0;
      trx_error_o <= 1'b0;
      restart_o   <= 1'b0;
      remain_q    <= '0;
      addr_q      <= '0;
      sel_q       <= '0;
      limit_q     <= '0;
      csh_q       <= '0;
      rwr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      split_q     <= split_d;
      trx_done_o  <= done_d;
      trx_error_o <= error_d;
      restart_o   <= restart_d;
      if (accept) begin
        limit_q <= t_burst_max_i;
        csh_q   <= t_csh_cycles_i;
        rwr_q   <= t_rwr_i;
        if (hit && (trx_len_i != '0)) begin
          remain_q <= trx_len_i;
          addr_q   <= trx_addr_i;
          sel_q    <= hit_sel;
        end
      end else if ((state_q == ACTIVE) && beat_i) begin
        remain_q <= remain_q - LenOne;
        addr_q   <= addr_q + AddrStep;
      end
    end
  end

  assign trx_ready_o    = (state_q == IDLE);
  assign trans_active_o = (state_q != IDLE);
  assign cur_addr_o     = addr_q;
  assign cs_no          = (state_q == ACTIVE) ? ~sel_q : '1;

endmodule

// File: doc/hyperbus_trx_timer.md
HYPERBUS_TRX_TIMER -- requirements
Module: hyperbus_trx_timer

Interface
REQ-001 The block SHALL have parameter NumChips, default 2, meaning number of chip selects (>=1).
REQ-002 The block SHALL have parameter AddrWidth, default 32, meaning transaction byte-address width.
REQ-003 The block SHALL have parameter BurstWidth, default 16, meaning width of the burst-cycle limit and the length field.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1, with asynchronous, active-low reset.
REQ-006 The block SHALL have port t_burst_max_i, input, BurstWidth, max cycles per CS-low window; 0 disables the limit.
REQ-007 The block SHALL have port t_csh_cycles_i, input, 4, minimum CS-high cycles.
REQ-008 The block SHALL have port t_rwr_i, input, 4, read/write recovery cycles after CS-high.
REQ-009 The block SHALL have ports chip_start_i and chip_end_i, input, NumChips x AddrWidth, per-chip address ranges; start inclusive, end exclusive.
REQ-010 The block SHALL have port trx_valid_i, input, 1, transaction request.
REQ-011 The block SHALL have port trx_ready_o, output, 1, request accept.
REQ-012 The block SHALL have port trx_addr_i, input, AddrWidth, start byte address.
REQ-013 The block SHALL have port trx_len_i, input, BurstWidth, length in 16-bit words.
REQ-014 The block SHALL have port beat_i, input, 1, PHY transferred one word this cycle.
REQ-015 The block SHALL have port cs_no, output, NumChips, active-low chip selects.
REQ-016 The block SHALL have port cur_addr_o, output, AddrWidth, byte address of the next word.
REQ-017 The block SHALL have ports restart_o, trx_done_o and trx_error_o, output, 1 each, single-cycle pulses.
REQ-018 The block SHALL have port trans_active_o, output, 1, which drives the config-register busy input.

Function
REQ-019 The block SHALL implement states IDLE, ACTIVE, CSH and RWR; trx_ready_o = (state==IDLE); trans_active_o = (state!=IDLE).
REQ-020 On accept (valid&ready), the block SHALL decode chip i where start_i<=addr<end_i, the lowest index winning; t_burst_max, t_csh and t_rwr SHALL be latched at accept.
REQ-021 On a decode miss, the block SHALL stay in IDLE, keep all cs_no high, and pulse trx_error_o in the next cycle.
REQ-022 On a hit with trx_len_i==0, the block SHALL stay in IDLE and pulse trx_done_o in the next cycle without asserting CS.
REQ-023 On a hit with len>0, the block SHALL load remain=len and cur_addr=addr, go to ACTIVE next cycle, and drive cs_no[sel] low only while in ACTIVE.
REQ-024 In ACTIVE, each beat_i SHALL decrement remain and add 2 to cur_addr, with wrap modulo 2^AddrWidth; beat_i outside ACTIVE SHALL be ignored.
REQ-025 The burst counter SHALL reset to 0 on ACTIVE entry and increment each ACTIVE cycle.
REQ-026 A beat with remain==1 SHALL cause transition to CSH, with the split flag cleared.
REQ-027 Otherwise, if the limit is nonzero and the counter equals limit-1, the block SHALL go to CSH with the split flag set; the final beat takes priority when both occur in the same cycle.
REQ-028 The block SHALL stay in CSH for max(t_csh,1) cycles with all cs_no high, then go to RWR.
REQ-029 The block SHALL stay in RWR for t_rwr cycles; t_rwr==0 SHALL skip RWR, with CSH exiting directly to the RWR-exit target.
REQ-030 On RWR exit with split set, the block SHALL return to ACTIVE on the same chip and pulse restart_o in the first ACTIVE cycle, with cur_addr and remain retained.
REQ-031 On RWR exit with split clear, the block SHALL go to IDLE and pulse trx_done_o in the first IDLE cycle.
REQ-032 At most one cs_no bit SHALL be low at any time.

Reset
REQ-033 While rst_ni is low, the block SHALL force state IDLE, all cs_no high, cur_addr_o=0, all pulses 0, trx_ready_o=1 and trans_active_o=0, including when reset is asserted mid-transaction.

Verification
REQ-034 Chips [0,0x1000) and [0x1000,0x2000); addr 0x1004, len 3, limit 0, csh 1, rwr 2, beats every cycle -> cs_no=2'b01 for 3 cycles, cur_addr 0x1004->0x100A, 1 CSH cycle, 2 RWR cycles, then trx_done_o.
REQ-035 Addr 0x3000 -> trx_error_o pulses once, cs_no stays 2'b11, trans_active_o stays 0.
REQ-036 Len 10, limit 4, continuous beats -> CS-low windows of 4, 4 and 2 cycles, two restart_o pulses, one done pulse, final cur_addr = start+20.
REQ-037 Limit 4 with the final beat at counter 3 -> no split, no restart_o, single CSH/RWR, then done.
REQ-038 Reset asserted in ACTIVE with remain 5 -> cs_no immediately 2'b11; after release, trx_ready_o=1 and a new request is accepted normally.
REQ-039 csh 0, rwr 0 -> exactly one CS-high cycle before IDLE; overlapping ranges with addr in both -> chip 0 selected.
